// File: rtl/dm_arbiter.sv
// dm_arbiter: sole master of the single-port data memory.
// Clears the whole memory after reset, then grants one access per cycle to
// either the core port (0) or the debug/DMA loader port (1) with
// round-robin tie-breaking. Responses are registered one cycle after grant.
// Grants and the memory write strobe are qualified by reset, so every
// output drops to zero the moment reset asserts, even between clock edges.
module dm_arbiter #(
  parameter int AW      = 10,
  parameter bit INIT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        we0,
  input  logic [31:0] addr0,
  input  logic [31:0] wdata0,
  input  logic [31:0] pc0,
  output logic        gnt0,
  output logic        rvalid0,
  output logic [31:0] rdata0,
  output logic        err0,
  input  logic        req1,
  input  logic        we1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  input  logic [31:0] pc1,
  output logic        gnt1,
  output logic        rvalid1,
  output logic [31:0] rdata1,
  output logic        err1,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_pc,
  input  logic [31:0] mem_rdata,
  output logic        init_done
);

  localparam logic [0:0]    ST_INIT   = 1'b0;
  localparam logic [0:0]    ST_RUN    = 1'b1;
  localparam logic [AW-1:0] LAST_WORD = '1;

  logic [0:0]    state;
  logic [AW-1:0] sweepCnt;
  logic          last;
  logic          initActive;
  logic          runActive;
  logic          inRange0;
  logic          inRange1;
  logic          sel0;
  logic          sel1;
  logic          contention;

  // Decode FSM activity, address range and the round-robin winner for this cycle
  always_comb begin
    initActive = reset && (state == ST_INIT);
    runActive  = reset && (state == ST_RUN);
    inRange0   = ((addr0 >> (AW + 2)) == 32'd0);
    inRange1   = ((addr1 >> (AW + 2)) == 32'd0);
    contention = runActive && req0 && req1;
    sel1       = runActive && req1 && (!req0 || !last);
    sel0       = runActive && req0 && !sel1;
  end

  assign gnt0      = sel0;
  assign gnt1      = sel1;
  assign init_done = runActive;

  // Steer the memory bus: clear sweep in INIT, otherwise the winning port's fields
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    mem_pc    = 32'd0;
    if (initActive) begin
      mem_we   = 1'b1;
      mem_addr = {{(30 - AW){1'b0}}, sweepCnt, 2'b00};
    end else if (sel0) begin
      mem_we    = we0 && inRange0;
      mem_addr  = addr0;
      mem_wdata = wdata0;
      mem_pc    = pc0;
    end else if (sel1) begin
      mem_we    = we1 && inRange1;
      mem_addr  = addr1;
      mem_wdata = wdata1;
      mem_pc    = pc1;
    end
  end

  // Sweep counter walks every word once, then the FSM settles in RUN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= INIT_EN ? ST_INIT : ST_RUN;
      sweepCnt <= '0;
    end else if (state == ST_INIT) begin
      sweepCnt <= sweepCnt + 1'b1;
      if (sweepCnt == LAST_WORD) begin
        state <= ST_RUN;
      end
    end
  end

  // Remember who won the last contended cycle so the other port wins the next one
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last <= 1'b1;
    end else if (contention) begin
      last <= sel1;
    end
  end

  // Register the port 0 response at its grant edge; stores and errors return zero data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rvalid0 <= 1'b0;
      rdata0  <= 32'd0;
      err0    <= 1'b0;
    end else begin
      rvalid0 <= sel0;
      rdata0  <= (sel0 && !we0 && inRange0) ? mem_rdata : 32'd0;
      err0    <= sel0 && !inRange0;
    end
  end

  // Register the port 1 response at its grant edge; stores and errors return zero data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rvalid1 <= 1'b0;
      rdata1  <= 32'd0;
      err1    <= 1'b0;
    end else begin
      rvalid1 <= sel1;
      rdata1  <= (sel1 && !we1 && inRange1) ? mem_rdata : 32'd0;
      err1    <= sel1 && !inRange1;
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed bench for dm_arbiter with a 16-word memory (AW=4).
// The bench owns a behavioural memory that starts filled with non-zero
// values, so the clear sweep is observable through later load data.
module tb_dm_arbiter;

  localparam int AW = 4;

  logic        clk;
  logic        reset;
  logic        req0, we0, gnt0, rvalid0, err0;
  logic [31:0] addr0, wdata0, pc0, rdata0;
  logic        req1, we1, gnt1, rvalid1, err1;
  logic [31:0] addr1, wdata1, pc1, rdata1;
  logic        mem_we, init_done;
  logic [31:0] mem_addr, mem_wdata, mem_pc, mem_rdata;
  logic        preload;
  logic [31:0] memArr [0:15];

  int testCount;
  int failCount;

  dm_arbiter #(.AW(AW), .INIT_EN(1'b1)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .pc0(pc0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0), .err0(err0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .pc1(pc1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1), .err1(err1),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_pc(mem_pc), .mem_rdata(mem_rdata), .init_done(init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port memory with a preload of recognisable junk
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) memArr[i] <= 32'hA5A5_0000 | 32'(i);
    end else if (mem_we) begin
      memArr[mem_addr[5:2]] <= mem_wdata;
    end
  end
  assign mem_rdata = memArr[mem_addr[5:2]];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkBit(input string tag, input logic observed, input logic expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int port, input logic r, input logic w,
                               input logic [31:0] a, input logic [31:0] d, input logic [31:0] p);
    if (port == 0) begin
      req0 = r; we0 = w; addr0 = a; wdata0 = d; pc0 = p;
    end else begin
      req1 = r; we1 = w; addr1 = a; wdata1 = d; pc1 = p;
    end
  endtask

  // Random-phase model state
  logic        pReq [2];
  logic        pWe [2];
  logic [31:0] pAddr [2];
  logic [31:0] pData [2];
  int          waitCnt [2];
  logic        eValid [2];
  logic [31:0] eRdata [2];
  logic        eErr [2];
  logic [31:0] shadow [16];
  logic        mLast;
  logic [5:0]  expG0;
  int          win;
  int          sel;

  initial begin
    testCount = 0;
    failCount = 0;
    reset     = 1'b0;
    preload   = 1'b1;
    applyStimulus(0, 1'b1, 1'b0, 32'h8, 32'h0, 32'h100);
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);

    // Reset held for three cycles: everything quiet, request stays pending
    repeat (3) begin
      @(negedge clk); #1;
      checkBit("rst_mem_we", mem_we, 1'b0);
      checkBit("rst_gnt0", gnt0, 1'b0);
      checkBit("rst_init_done", init_done, 1'b0);
      checkBit("rst_rvalid0", rvalid0, 1'b0);
      checkOutput("rst_mem_addr", mem_addr, 32'h0);
    end

    // Release: sixteen sweep cycles clear words 0..15, no grant while sweeping
    @(negedge clk);
    reset   = 1'b1;
    preload = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checkBit("sweep_we", mem_we, 1'b1);
      checkOutput("sweep_addr", mem_addr, 32'(i * 4));
      checkOutput("sweep_wdata", mem_wdata, 32'h0);
      checkBit("sweep_gnt0", gnt0, 1'b0);
      checkBit("sweep_done", init_done, 1'b0);
    end

    // First RUN cycle: pending load finally granted
    @(negedge clk); #1;
    checkBit("run_init_done", init_done, 1'b1);
    checkBit("run_gnt0", gnt0, 1'b1);
    checkBit("run_mem_we", mem_we, 1'b0);
    checkOutput("run_mem_addr", mem_addr, 32'h8);
    checkOutput("cleared_w0", memArr[0], 32'h0);
    checkOutput("cleared_w15", memArr[15], 32'h0);
    @(negedge clk);
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    #1;
    checkBit("ld8_rvalid", rvalid0, 1'b1);
    checkOutput("ld8_rdata", rdata0, 32'h0);
    checkBit("ld8_err", err0, 1'b0);
    @(negedge clk); #1;
    checkBit("ld8_pulse", rvalid0, 1'b0);

    // Both ports hold requests six cycles: port 0 wins first, then alternate
    expG0 = 6'b010101;
    @(negedge clk);
    applyStimulus(0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h110);
    applyStimulus(1, 1'b1, 1'b0, 32'h4, 32'h0, 32'h210);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checkBit("rr_gnt0", gnt0, expG0[i]);
      checkBit("rr_gnt1", gnt1, !expG0[i]);
      if (i > 0) begin
        checkBit("rr_rvalid0", rvalid0, expG0[i-1]);
        checkBit("rr_rvalid1", rvalid1, !expG0[i-1]);
      end
    end
    @(negedge clk);
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    #1;
    checkBit("rr_tail_rvalid1", rvalid1, 1'b1);
    checkBit("rr_tail_rvalid0", rvalid0, 1'b0);
    checkBit("rr_idle_we", mem_we, 1'b0);

    // Store then load the same word on consecutive grants
    @(negedge clk);
    applyStimulus(0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 32'h200);
    #1;
    checkBit("st_gnt0", gnt0, 1'b1);
    checkBit("st_mem_we", mem_we, 1'b1);
    checkOutput("st_mem_addr", mem_addr, 32'h10);
    checkOutput("st_mem_wdata", mem_wdata, 32'hDEADBEEF);
    checkOutput("st_mem_pc", mem_pc, 32'h200);
    @(negedge clk);
    applyStimulus(0, 1'b1, 1'b0, 32'h10, 32'h0, 32'h204);
    #1;
    checkBit("ld_gnt0", gnt0, 1'b1);
    checkBit("ld_mem_we", mem_we, 1'b0);
    checkBit("st_rvalid0", rvalid0, 1'b1);
    checkOutput("st_rdata0", rdata0, 32'h0);
    @(negedge clk);
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    #1;
    checkBit("ld_rvalid0", rvalid0, 1'b1);
    checkOutput("ld_rdata0", rdata0, 32'hDEADBEEF);
    @(negedge clk); #1;
    checkBit("ld_pulse", rvalid0, 1'b0);

    // Range edges on port 1: last word, first word past the end, far address
    @(negedge clk);
    applyStimulus(1, 1'b1, 1'b1, 32'h3C, 32'h5555AAAA, 32'h300);
    #1;
    checkBit("top_gnt1", gnt1, 1'b1);
    checkBit("top_mem_we", mem_we, 1'b1);
    checkOutput("top_mem_addr", mem_addr, 32'h3C);
    @(negedge clk);
    applyStimulus(1, 1'b1, 1'b1, 32'h40, 32'h77, 32'h304);
    #1;
    checkBit("oor_st_gnt1", gnt1, 1'b1);
    checkBit("oor_st_mem_we", mem_we, 1'b0);
    checkBit("top_rvalid1", rvalid1, 1'b1);
    checkBit("top_err1", err1, 1'b0);
    checkOutput("top_rdata1", rdata1, 32'h0);
    @(negedge clk);
    applyStimulus(1, 1'b1, 1'b0, 32'h1000, 32'h0, 32'h308);
    #1;
    checkBit("oor_ld_gnt1", gnt1, 1'b1);
    checkBit("oor_ld_mem_we", mem_we, 1'b0);
    checkBit("oor_st_rvalid1", rvalid1, 1'b1);
    checkBit("oor_st_err1", err1, 1'b1);
    checkOutput("oor_st_rdata1", rdata1, 32'h0);
    @(negedge clk);
    applyStimulus(1, 1'b1, 1'b0, 32'h3F, 32'h0, 32'h30C);
    #1;
    checkBit("oor_ld_rvalid1", rvalid1, 1'b1);
    checkBit("oor_ld_err1", err1, 1'b1);
    checkOutput("oor_ld_rdata1", rdata1, 32'h0);
    checkOutput("oor_no_wrap", memArr[0], 32'h0);
    @(negedge clk);
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    #1;
    checkBit("lowbits_rvalid1", rvalid1, 1'b1);
    checkBit("lowbits_err1", err1, 1'b0);
    checkOutput("lowbits_rdata1", rdata1, 32'h5555AAAA);
    @(negedge clk); #1;
    checkBit("err_pulse", err1, 1'b0);

    // Contention with mixed store/load: winner drives the bus, loser follows
    @(negedge clk);
    applyStimulus(0, 1'b1, 1'b1, 32'h20, 32'h1234, 32'h400);
    applyStimulus(1, 1'b1, 1'b0, 32'h10, 32'h0, 32'h500);
    #1;
    checkBit("mix_gnt0", gnt0, 1'b1);
    checkBit("mix_gnt1", gnt1, 1'b0);
    checkBit("mix_mem_we", mem_we, 1'b1);
    checkOutput("mix_mem_addr", mem_addr, 32'h20);
    checkOutput("mix_mem_pc", mem_pc, 32'h400);
    @(negedge clk);
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    #1;
    checkBit("mix2_gnt1", gnt1, 1'b1);
    checkOutput("mix2_mem_addr", mem_addr, 32'h10);
    checkOutput("mix2_mem_pc", mem_pc, 32'h500);
    checkBit("mix2_rvalid0", rvalid0, 1'b1);
    @(negedge clk);
    applyStimulus(0, 1'b1, 1'b0, 32'h20, 32'h0, 32'h404);
    applyStimulus(1, 1'b1, 1'b0, 32'h20, 32'h0, 32'h504);
    #1;
    checkBit("mix3_rvalid1", rvalid1, 1'b1);
    checkOutput("mix3_rdata1", rdata1, 32'hDEADBEEF);
    checkBit("mix3_gnt1", gnt1, 1'b1);
    checkBit("mix3_gnt0", gnt0, 1'b0);
    @(negedge clk);
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    #1;
    checkBit("mix4_gnt0", gnt0, 1'b1);
    checkOutput("mix4_rdata1", rdata1, 32'h1234);
    @(negedge clk);
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    #1;
    checkOutput("mix5_rdata0", rdata0, 32'h1234);

    // Reset asserted mid-access in RUN: grant vanishes at once, no response
    @(negedge clk);
    applyStimulus(0, 1'b1, 1'b0, 32'h10, 32'h0, 32'h600);
    #1;
    checkBit("midacc_gnt0", gnt0, 1'b1);
    #1 reset = 1'b0;
    #1;
    checkBit("midacc_rst_gnt0", gnt0, 1'b0);
    checkBit("midacc_rst_done", init_done, 1'b0);
    checkBit("midacc_rst_we", mem_we, 1'b0);
    @(negedge clk); #1;
    checkBit("midacc_no_rvalid", rvalid0, 1'b0);

    // Release, then reset again at sweep counter 5: sweep restarts at word 0
    reset = 1'b1;
    #1;
    checkBit("resweep_we", mem_we, 1'b1);
    checkOutput("resweep_addr0", mem_addr, 32'h0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk); #1;
      checkOutput("resweep_addr", mem_addr, 32'(k * 4));
    end
    reset = 1'b0;
    #1;
    checkBit("midsweep_rst_we", mem_we, 1'b0);
    checkOutput("midsweep_rst_addr", mem_addr, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("restart_addr", mem_addr, 32'h0);
    checkBit("restart_we", mem_we, 1'b1);
    for (int k = 1; k < 16; k++) begin
      @(negedge clk); #1;
      checkOutput("restart_sweep_addr", mem_addr, 32'(k * 4));
      checkBit("restart_sweep_gnt0", gnt0, 1'b0);
    end
    @(negedge clk); #1;
    checkBit("rerun_done", init_done, 1'b1);
    checkBit("rerun_gnt0", gnt0, 1'b1);
    @(negedge clk);
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    #1;
    checkBit("rerun_rvalid0", rvalid0, 1'b1);
    checkOutput("rerun_cleared", rdata0, 32'h0);

    // Randomised traffic against a scoreboard; memory is all zero here
    mLast = 1'b1;
    for (int i = 0; i < 16; i++) shadow[i] = 32'h0;
    for (int p = 0; p < 2; p++) begin
      pReq[p] = 1'b0; pWe[p] = 1'b0; pAddr[p] = 32'h0; pData[p] = 32'h0;
      waitCnt[p] = 0; eValid[p] = 1'b0; eRdata[p] = 32'h0; eErr[p] = 1'b0;
    end
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      checkBit("rnd_rvalid0", rvalid0, eValid[0]);
      checkBit("rnd_rvalid1", rvalid1, eValid[1]);
      if (eValid[0]) begin
        checkOutput("rnd_rdata0", rdata0, eRdata[0]);
        checkBit("rnd_err0", err0, eErr[0]);
      end
      if (eValid[1]) begin
        checkOutput("rnd_rdata1", rdata1, eRdata[1]);
        checkBit("rnd_err1", err1, eErr[1]);
      end
      for (int p = 0; p < 2; p++) begin
        if (!pReq[p] && ($urandom_range(0, 3) != 0)) begin
          pReq[p] = 1'b1;
          pWe[p]  = 1'($urandom_range(0, 1));
          sel     = int'($urandom_range(0, 7));
          if (sel == 7)      pAddr[p] = 32'h40 + (32'($urandom_range(0, 15)) << 2);
          else if (sel == 6) pAddr[p] = $urandom | 32'h8000_0000;
          else               pAddr[p] = 32'($urandom_range(0, 63));
          pData[p] = $urandom;
        end
      end
      applyStimulus(0, pReq[0], pWe[0], pAddr[0], pData[0], 32'h700);
      applyStimulus(1, pReq[1], pWe[1], pAddr[1], pData[1], 32'h800);
      #1;
      if (pReq[0] && pReq[1]) begin
        win   = mLast ? 0 : 1;
        mLast = (win == 1);
      end else if (pReq[0]) win = 0;
      else if (pReq[1])     win = 1;
      else                  win = -1;
      checkBit("rnd_gnt0", gnt0, win == 0);
      checkBit("rnd_gnt1", gnt1, win == 1);
      for (int p = 0; p < 2; p++) begin
        eValid[p] = (win == p);
        if (pReq[p] && win >= 0 && win != p) waitCnt[p]++;
        checkBit("rnd_starve", waitCnt[p] <= 1, 1'b1);
      end
      if (win >= 0) begin
        if (pAddr[win] < 32'h40) begin
          eErr[win]   = 1'b0;
          eRdata[win] = pWe[win] ? 32'h0 : shadow[pAddr[win][5:2]];
          if (pWe[win]) shadow[pAddr[win][5:2]] = pData[win];
        end else begin
          eErr[win]   = 1'b1;
          eRdata[win] = 32'h0;
        end
        pReq[win]    = 1'b0;
        waitCnt[win] = 0;
      end
    end
    @(negedge clk);
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    #1;
    checkBit("rnd_last_rvalid0", rvalid0, eValid[0]);
    checkBit("rnd_last_rvalid1", rvalid1, eValid[1]);
    if (eValid[0]) checkOutput("rnd_last_rdata0", rdata0, eRdata[0]);
    if (eValid[1]) checkOutput("rnd_last_rdata1", rdata1, eRdata[1]);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
